// File: rtl/bus_xfer_arbiter.sv
// Four-requester register-transfer arbiter: IDLE -> XFER -> ACK, one transfer per three cycles.
// Round-robin by default; define FIXED_PRIORITY_EN for fixed priority (requester 0 highest).
module bus_xfer_arbiter (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  req,
  input  logic [15:0] src_sel,
  input  logic [15:0] dst_sel,
  input  logic [3:0]  ba_req,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        BAout,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rout_q, rout_d;
  logic [15:0] rin_q, rin_d;
  logic        baout_q, baout_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic [1:0]  win_q, win_d;
  logic        found;
  logic [1:0]  win_idx;

`ifdef FIXED_PRIORITY_EN
  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    // Scanning downward leaves the lowest-numbered active requester as winner.
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    // Downward scan of offsets from the pointer: smallest offset wins, wrapping mod 4.
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rout_d  = 16'd0;
    rin_d   = 16'd0;
    baout_d = 1'b0;
    gnt_d   = 4'd0;
    done_d  = 4'd0;
    win_d   = win_q;
`ifndef FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          win_d   = win_idx;
          // Selectors are captured straight into the output registers, so later input changes are ignored.
          rout_d  = 16'd1 << src_sel[{win_idx, 2'b00} +: 4];
          rin_d   = 16'd1 << dst_sel[{win_idx, 2'b00} +: 4];
          baout_d = ba_req[win_idx];
          gnt_d   = 4'd1 << win_idx;
        end
      end
      XFER: begin
        state_d = ACK;
        done_d  = 4'd1 << win_q;
`ifndef FIXED_PRIORITY_EN
        ptr_d   = win_q + 2'd1;
`endif
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rout_q  <= 16'd0;
      rin_q   <= 16'd0;
      baout_q <= 1'b0;
      gnt_q   <= 4'd0;
      done_q  <= 4'd0;
      win_q   <= 2'd0;
`ifndef FIXED_PRIORITY_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      rout_q  <= rout_d;
      rin_q   <= rin_d;
      baout_q <= baout_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      win_q   <= win_d;
`ifndef FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign Rout      = rout_q;
  assign Rin       = rin_q;
  assign BAout     = baout_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
